// File: rtl/sw_debounce_pkg.sv
// Board-level timing constants shared by the switch front-end.
// The default debounce window is derived from the system clock.
package sw_debounce_pkg;

    localparam int CLK_FREQ_HZ = 100_000_000;
    localparam int DEB_MS      = 10;
    localparam int DEB_CYCLES  = CLK_FREQ_HZ / 1000 * DEB_MS;

    // Counter width for a window of 'cycles' stable samples (terminal value cycles-1)
    function automatic int deb_cnt_w(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-FF synchroniser, stability counter, debounced level
// and registered rise/fall pulses.
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic flip
);

    localparam int                CNT_W = deb_cnt_w(DEB_CYCLES);
    localparam logic [CNT_W-1:0]  TERM  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  ZERO  = CNT_W'(0);

    logic             s1_r;
    logic             s2_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             stable_r;
    logic             rise_r;
    logic             fall_r;
    logic             flip_s;

    // Next counter value and terminal-count detection; any agreement clears the count
    always_comb begin
        cnt_nxt_s = cnt_r;
        flip_s    = 1'b0;
        if (s2_r == stable_r) begin
            cnt_nxt_s = ZERO;
        end else if (cnt_r == TERM) begin
            cnt_nxt_s = ZERO;
            flip_s    = 1'b1;
        end else begin
            cnt_nxt_s = cnt_r + ONE;
        end
    end

    // Synchroniser, counter, stable level and edge pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r     <= 1'b0;
            s2_r     <= 1'b0;
            cnt_r    <= ZERO;
            stable_r <= 1'b0;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end else begin
            s1_r     <= din;
            s2_r     <= s1_r;
            cnt_r    <= cnt_nxt_s;
            stable_r <= stable_r ^ flip_s;
            rise_r   <= flip_s & ~stable_r;
            fall_r   <= flip_s & stable_r;
        end
    end

    assign dout = stable_r;
    assign rise = rise_r;
    assign fall = fall_r;
    // Combinational: lets the parent register an aggregate strobe on the same edge
    assign flip = flip_s;

endmodule

// File: rtl/sw_debounce.sv
// Debounces WIDTH raw slide switches into a clean code for the 3-8 decoder,
// with per-bit rise/fall strobes and an any-bit change strobe.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int DEB_CYCLES = sw_debounce_pkg::DEB_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic             sw_chg,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    logic [WIDTH-1:0] stable_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] flip_s;
    logic             chg_r;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_bit (
            .clk  (clk),
            .rst  (rst),
            .din  (sw_in[i]),
            .dout (stable_s[i]),
            .rise (rise_s[i]),
            .fall (fall_s[i]),
            .flip (flip_s[i])
        );
    end

    // Change strobe: registered on the same edge as the bits that update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chg_r <= 1'b0;
        end else begin
            chg_r <= |flip_s;
        end
    end

    assign sw_out  = stable_s;
    assign sw_rise = rise_s;
    assign sw_fall = fall_s;
    assign sw_chg  = chg_r;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with WIDTH=3, DEB_CYCLES=4: vector table plus
// hand-written bounce, staggered-change and mid-count reset sequences.
module tb_sw_debounce;

    logic       clk;
    logic       rst;
    logic [2:0] sw_in;
    logic [2:0] sw_out;
    logic       sw_chg;
    logic [2:0] sw_rise;
    logic [2:0] sw_fall;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic       rst;
        logic [2:0] sw;
        logic [2:0] out;
        logic       chg;
        logic [2:0] rise;
        logic [2:0] fall;
    } vec_t;

    vec_t tbl[$];

    sw_debounce #(
        .WIDTH      (3),
        .DEB_CYCLES (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_in   (sw_in),
        .sw_out  (sw_out),
        .sw_chg  (sw_chg),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] o, input logic c,
                           input logic [2:0] r, input logic [2:0] f);
        chk({tag, " sw_out"},  {29'd0, sw_out},  {29'd0, o});
        chk({tag, " sw_chg"},  {31'd0, sw_chg},  {31'd0, c});
        chk({tag, " sw_rise"}, {29'd0, sw_rise}, {29'd0, r});
        chk({tag, " sw_fall"}, {29'd0, sw_fall}, {29'd0, f});
    endtask

    task automatic add(input logic r, input logic [2:0] s, input logic [2:0] o,
                       input logic c, input logic [2:0] ri, input logic [2:0] fa);
        vec_t v;
        v.rst = r; v.sw = s; v.out = o; v.chg = c; v.rise = ri; v.fall = fa;
        tbl.push_back(v);
    endtask

    task automatic add_n(input int n, input logic r, input logic [2:0] s, input logic [2:0] o);
        for (int k = 0; k < n; k++) add(r, s, o, 1'b0, 3'b000, 3'b000);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Held in reset with switches high: nothing may come out
        add_n(10, 1'b1, 3'b101, 3'b000);
        add_n(3,  1'b0, 3'b000, 3'b000);
        // 000 -> 011: edges E0..E0+4 quiet, update at E0+5
        add_n(5,  1'b0, 3'b011, 3'b000);
        add(1'b0, 3'b011, 3'b011, 1'b1, 3'b011, 3'b000);
        add_n(1,  1'b0, 3'b011, 3'b011);
        // 3-cycle glitch on bit2 never reaches the output
        add_n(3,  1'b0, 3'b111, 3'b011);
        add_n(5,  1'b0, 3'b011, 3'b011);
        // 011 -> 101: bit2 rises, bit1 falls on the same edge
        add_n(5,  1'b0, 3'b101, 3'b011);
        add(1'b0, 3'b101, 3'b101, 1'b1, 3'b100, 3'b010);
        add_n(1,  1'b0, 3'b101, 3'b101);
        // 101 -> 011
        add_n(5,  1'b0, 3'b011, 3'b101);
        add(1'b0, 3'b011, 3'b011, 1'b1, 3'b010, 3'b100);
        add_n(1,  1'b0, 3'b011, 3'b011);

        rst   = 1'b1;
        sw_in = 3'b101;
        #2;
        chk_all("async reset", 3'b000, 1'b0, 3'b000, 3'b000);

        foreach (tbl[i]) begin
            rst   = tbl[i].rst;
            sw_in = tbl[i].sw;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].out, tbl[i].chg, tbl[i].rise, tbl[i].fall);
        end

        // Staggered: bit0 falls at edge 0, bit1 falls at edge 2 -> two chg pulses
        for (int k = 0; k < 10; k++) begin
            sw_in = (k < 2) ? 3'b010 : 3'b000;
            tick();
            chk_all($sformatf("stagger%0d", k),
                    (k < 5) ? 3'b011 : ((k < 7) ? 3'b010 : 3'b000),
                    (k == 5) || (k == 7),
                    3'b000,
                    (k == 5) ? 3'b001 : ((k == 7) ? 3'b010 : 3'b000));
        end

        // Bounce on bit0: 1,1,0,0,1,1,0,0 then steady 1 from edge 8 -> update at edge 13
        for (int k = 0; k < 20; k++) begin
            sw_in = (k >= 8 || k == 0 || k == 1 || k == 4 || k == 5) ? 3'b001 : 3'b000;
            tick();
            chk_all($sformatf("bounce%0d", k),
                    (k >= 13) ? 3'b001 : 3'b000,
                    k == 13,
                    (k == 13) ? 3'b001 : 3'b000,
                    3'b000);
        end

        // Reset while bit1 counter is at 2
        sw_in = 3'b011;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_all($sformatf("precount%0d", k), 3'b001, 1'b0, 3'b000, 3'b000);
        end
        rst   = 1'b1;
        sw_in = 3'b010;
        #1;
        chk_all("midcount reset", 3'b000, 1'b0, 3'b000, 3'b000);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk_all($sformatf("postrst%0d", k),
                    (k >= 5) ? 3'b010 : 3'b000,
                    k == 5,
                    (k == 5) ? 3'b010 : 3'b000,
                    3'b000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
